// File: rtl/svetofor_pkg.sv
// Shared constants, state-word helpers and FSM/job encodings for the svetofor APB master.
package svetofor_pkg;

   localparam logic [1:0]  LAMP_RED               = 2'b00;
   localparam logic [1:0]  LAMP_YELLOW            = 2'b01;
   localparam logic [1:0]  LAMP_GREEN             = 2'b10;

   localparam logic [31:0] CONTROL_REG_ADDR_DEF   = 32'h0;
   localparam logic [31:0] CURRENT_STATE_ADDR_DEF = 32'h4;
   localparam logic [31:0] ADVANCE_CMD            = 32'h1;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} apb_fsm_t;
   typedef enum logic [1:0] {JOB_POLL, JOB_ADV, JOB_PED} job_t;

   typedef struct packed {
      logic [1:0] light1;
      logic [1:0] light2;
   } state_word_t;

   function automatic logic [3:0] pack_state(input logic [1:0] l1, input logic [1:0] l2);
      return {l1, l2};
   endfunction

   function automatic state_word_t unpack_state(input logic [3:0] w);
      state_word_t s;
      s.light1 = w[3:2];
      s.light2 = w[1:0];
      return s;
   endfunction

endpackage

// File: rtl/svetofor_req_latch.sv
// Request latch: optional rising-edge detect feeding a sticky pending flag with clear.
module svetofor_req_latch #(
   parameter bit EDGE_DET = 1'b1
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_req,
   input  logic i_clr,
   output logic o_pending,
   output logic o_active
);

   logic r_req_d;
   logic r_pending;
   logic w_set;

   assign w_set     = EDGE_DET ? (i_req & ~r_req_d) : i_req;
   assign o_pending = r_pending;
   // o_active lets the consumer act on a request in the same cycle it arrives
   assign o_active  = r_pending | w_set;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_req_d   <= 1'b0;
         r_pending <= 1'b0;
      end else begin
         r_req_d <= i_req;
         if (w_set)
            r_pending <= 1'b1;
         else if (i_clr)
            r_pending <= 1'b0;
      end
   end

endmodule

// File: rtl/svetofor_apb_master.sv
// APB master for the svetofor traffic light: periodic state polling plus
// pedestrian / software advance writes to the control register.
module svetofor_apb_master
   import svetofor_pkg::*;
#(
   parameter logic [31:0] CONTROL_REG_ADDR   = CONTROL_REG_ADDR_DEF,
   parameter logic [31:0] CURRENT_STATE_ADDR = CURRENT_STATE_ADDR_DEF,
   parameter int          POLL_PERIOD        = 16,
   parameter int          TIMEOUT            = 8,
   parameter logic [1:0]  GREEN              = LAMP_GREEN
) (
   input  logic        PCLK,
   input  logic        PRESETn,
   input  logic        ped_req,
   input  logic        sw_advance,
   output logic        PSEL,
   output logic        PENABLE,
   output logic        PWRITE,
   output logic [31:0] PADDR,
   output logic [31:0] PWDATA,
   input  logic [31:0] PRDATA,
   input  logic        PREADY,
   output logic [1:0]  light1,
   output logic [1:0]  light2,
   output logic        state_valid,
   output logic        ped_pending,
   output logic        apb_err,
   output logic        busy
);

   localparam int PW = $clog2(POLL_PERIOD);
   localparam int TW = $clog2(TIMEOUT) + 1;

   apb_fsm_t    r_state;
   job_t        r_job;
   logic [PW-1:0] r_poll_cnt;
   logic        r_poll_due;
   logic [TW-1:0] r_to_cnt;
   logic        r_psel;
   logic        r_penable;
   logic        r_pwrite;
   logic [31:0] r_paddr;
   logic [31:0] r_pwdata;
   state_word_t r_lights;
   logic        r_state_valid;
   logic        r_apb_err;
   logic        r_stale;

   logic w_wrap;
   logic w_poll_due;
   logic w_adv_active;
   logic w_ped_active;
   logic w_ped_ok;
   logic w_done_ok;
   logic w_clr_adv;
   logic w_clr_ped;
   logic w_unused_adv_q;
   logic w_unused_prdata;

   assign w_wrap          = (r_poll_cnt == PW'(POLL_PERIOD - 1));
   assign w_poll_due      = r_poll_due | w_wrap;
   assign w_done_ok       = (r_state == ACCESS) && PREADY;
   assign w_clr_adv       = w_done_ok && (r_job == JOB_ADV);
   assign w_clr_ped       = w_done_ok && (r_job == JOB_PED);
   // After any advance write the cached colours are stale until the next poll,
   // which prevents a second advance on an outdated GREEN.
   assign w_ped_ok        = w_ped_active && r_state_valid && !r_stale &&
                            (r_lights.light1 == GREEN);
   assign w_unused_prdata = ^PRDATA[31:4];

   svetofor_req_latch #(.EDGE_DET(1'b1)) u_ped_latch (
      .i_clk     (PCLK),
      .i_rst_n   (PRESETn),
      .i_req     (ped_req),
      .i_clr     (w_clr_ped),
      .o_pending (ped_pending),
      .o_active  (w_ped_active)
   );

   svetofor_req_latch #(.EDGE_DET(1'b0)) u_adv_latch (
      .i_clk     (PCLK),
      .i_rst_n   (PRESETn),
      .i_req     (sw_advance),
      .i_clr     (w_clr_adv),
      .o_pending (w_unused_adv_q),
      .o_active  (w_adv_active)
   );

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_poll_cnt <= '0;
         r_poll_due <= 1'b0;
      end else begin
         r_poll_cnt <= w_wrap ? '0 : r_poll_cnt + PW'(1);
         if (w_wrap)
            r_poll_due <= 1'b1;
         else if (w_done_ok && (r_job == JOB_POLL))
            r_poll_due <= 1'b0;
      end
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         r_state       <= IDLE;
         r_job         <= JOB_POLL;
         r_to_cnt      <= '0;
         r_psel        <= 1'b0;
         r_penable     <= 1'b0;
         r_pwrite      <= 1'b0;
         r_paddr       <= '0;
         r_pwdata      <= '0;
         r_lights      <= unpack_state(pack_state(LAMP_RED, LAMP_RED));
         r_state_valid <= 1'b0;
         r_apb_err     <= 1'b0;
         r_stale       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_adv_active || w_ped_ok) begin
                  r_job    <= w_adv_active ? JOB_ADV : JOB_PED;
                  r_paddr  <= CONTROL_REG_ADDR;
                  r_pwrite <= 1'b1;
                  r_pwdata <= ADVANCE_CMD;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end else if (w_poll_due) begin
                  r_job    <= JOB_POLL;
                  r_paddr  <= CURRENT_STATE_ADDR;
                  r_pwrite <= 1'b0;
                  r_pwdata <= '0;
                  r_psel   <= 1'b1;
                  r_state  <= SETUP;
               end
            end
            SETUP: begin
               r_penable <= 1'b1;
               r_to_cnt  <= '0;
               r_state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_state   <= DONE;
                  if (r_job == JOB_POLL) begin
                     r_lights      <= unpack_state(PRDATA[3:0]);
                     r_state_valid <= 1'b1;
                     r_stale       <= 1'b0;
                  end else begin
                     r_stale <= 1'b1;
                  end
               end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
                  r_psel    <= 1'b0;
                  r_penable <= 1'b0;
                  r_apb_err <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_to_cnt <= r_to_cnt + TW'(1);
               end
            end
            DONE:    r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign PSEL        = r_psel;
   assign PENABLE     = r_penable;
   assign PWRITE      = r_pwrite;
   assign PADDR       = r_paddr;
   assign PWDATA      = r_pwdata;
   assign light1      = r_lights.light1;
   assign light2      = r_lights.light2;
   assign state_valid = r_state_valid;
   assign apb_err     = r_apb_err;
   assign busy        = (r_state != IDLE);

endmodule
